// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and op-decode helpers for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic is_reserved_op(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return ~op[2] & ~op[0];
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return ~op[2] & op[1];
    endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Restoring divider datapath: one quotient bit per enabled step, operating on unsigned magnitudes.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH:0]   w_partial;
    logic [WIDTH:0]   w_diff;
    logic             w_neg;

    // partial < 2*divisor, so the difference always fits a signed WIDTH+1 result
    assign w_partial = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_partial - {1'b0, r_divisor};
    assign w_neg     = w_diff[WIDTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
        end else if (i_load) begin
            r_rem     <= '0;
            r_quo     <= i_dividend;
            r_divisor <= i_divisor;
        end else if (i_step) begin
            r_rem <= w_neg ? w_partial[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], ~w_neg};
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers: shift-add multiplier, restoring divider, cancel support.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_div_zero;
    logic                 r_is_div;
    logic                 r_neg_res;
    logic                 r_neg_rem;
    logic                 r_b_zero;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_mag_a;
    logic [2*WIDTH-1:0]   r_mul_p;

    logic                 w_start_ok;
    logic                 w_go_iter;
    logic                 w_mthi;
    logic                 w_mtlo;
    logic                 w_step;
    logic                 w_fix_write;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_mul_add;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_div_q;
    logic [WIDTH-1:0]     w_div_r;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;

    assign w_a_neg = is_signed_op(op) & a[WIDTH-1];
    assign w_b_neg = is_signed_op(op) & b[WIDTH-1];
    assign w_mag_a = w_a_neg ? -a : a;
    assign w_mag_b = w_b_neg ? -b : b;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (cancel) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_go_iter) w_state_next = ST_CALC;
                ST_CALC: if (r_cnt == CNT_W'(1)) w_state_next = ST_FIX;
                ST_FIX:  w_state_next = ST_IDLE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_start_ok  = (r_state == ST_IDLE) & start & ~cancel & ~is_reserved_op(op);
        w_go_iter   = w_start_ok & ~op[2];
        w_mthi      = w_start_ok & (op == OP_MTHI);
        w_mtlo      = w_start_ok & (op == OP_MTLO);
        w_step      = (r_state == ST_CALC) & ~cancel;
        w_fix_write = (r_state == ST_FIX) & ~cancel;
    end

    // Shift-add: add multiplicand into the upper half on LSB=1, then shift right with carry
    assign w_mul_add  = {1'b0, r_mul_p[2*WIDTH-1:WIDTH]} + (r_mul_p[0] ? {1'b0, r_mag_a} : '0);
    assign w_mul_next = {w_mul_add, r_mul_p[WIDTH-1:1]};

    assign w_prod = r_neg_res ? -r_mul_p : r_mul_p;
    assign w_quo  = r_neg_res ? -w_div_q : w_div_q;
    assign w_rem  = r_neg_rem ? -w_div_r : w_div_r;

    div_iter #(
        .WIDTH(WIDTH)
    ) u_div_iter (
        .clk         (clk),
        .resetn      (resetn),
        .i_load      (w_go_iter),
        .i_step      (w_step),
        .i_dividend  (w_mag_a),
        .i_divisor   (w_mag_b),
        .o_quotient  (w_div_q),
        .o_remainder (w_div_r)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_b_zero   <= 1'b0;
            r_a        <= '0;
            r_mag_a    <= '0;
            r_mul_p    <= '0;
        end else begin
            r_done <= w_fix_write;
            r_busy <= (w_state_next != ST_IDLE);
            if (w_go_iter) begin
                r_cnt     <= CNT_W'(WIDTH);
                r_is_div  <= is_div_op(op);
                r_neg_res <= w_a_neg ^ w_b_neg;
                r_neg_rem <= w_a_neg;
                r_b_zero  <= (b == '0);
                r_a       <= a;
                r_mag_a   <= w_mag_a;
                r_mul_p   <= {{WIDTH{1'b0}}, w_mag_b};
            end else if (w_step) begin
                r_cnt   <= r_cnt - 1'b1;
                r_mul_p <= w_mul_next;
            end
            if (w_start_ok) r_div_zero <= 1'b0;
            if (w_mthi) r_hi <= a;
            if (w_mtlo) r_lo <= a;
            if (w_fix_write) begin
                if (!r_is_div) begin
                    {r_hi, r_lo} <= w_prod;
                end else if (r_b_zero) begin
                    r_hi       <= r_a;
                    r_lo       <= '1;
                    r_div_zero <= 1'b1;
                end else begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end
            end
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32) with a scoreboard queue of expected HI/LO/div_zero results.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk    = 1'b0;
    logic         resetn = 1'b0;
    logic         start  = 1'b0;
    logic         cancel = 1'b0;
    logic [2:0]   op     = 3'b000;
    logic [W-1:0] a      = '0;
    logic [W-1:0] b      = '0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         div_zero;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .cancel   (cancel),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
        $display("[TB] check %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic step_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives start for one cycle (cycle 0); returns #1 into cycle 1 with operands scrambled.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        step_cycles(1);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic push_exp(input logic [W-1:0] h, input logic [W-1:0] l, input logic d);
        exp_t e;
        e.hi = h;
        e.lo = l;
        e.dz = d;
        sb.push_back(e);
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t                    e;
        logic signed [2*W-1:0]   ps;
        logic        [2*W-1:0]   pu;
        logic        [W-1:0]     min_neg;
        min_neg = {1'b1, {(W-1){1'b0}}};
        e = '0;
        case (o)
            OP_MULT: begin
                ps = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
                e.hi = ps[2*W-1:W];
                e.lo = ps[W-1:0];
            end
            OP_MULTU: begin
                pu = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                e.hi = pu[2*W-1:W];
                e.lo = pu[W-1:0];
            end
            default: begin
                if (y == '0) begin
                    e.hi = x;
                    e.lo = '1;
                    e.dz = 1'b1;
                end else if (o == OP_DIVU) begin
                    e.lo = x / y;
                    e.hi = x % y;
                end else if (x == min_neg && y == '1) begin
                    e.lo = min_neg;
                    e.hi = '0;
                end else begin
                    e.lo = $signed(x) / $signed(y);
                    e.hi = $signed(x) % $signed(y);
                end
            end
        endcase
        return e;
    endfunction

    // Entered in cycle cyc0 of an iterative op; expects done in cycle W+2 with busy high before it.
    task automatic wait_done(input string tag, input int cyc0);
        int   cyc;
        logic busy_ok;
        exp_t e;
        cyc     = cyc0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 200) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            step_cycles(1);
            cyc++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_latency"}, cyc, W + 2);
        chk({tag, "_busy_during"}, busy_ok, 1);
        chk({tag, "_busy_at_done"}, busy, 0);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '0;
        chk({tag, "_hi"}, hi, e.hi);
        chk({tag, "_lo"}, lo, e.lo);
        chk({tag, "_div_zero"}, div_zero, e.dz);
    endtask

    initial begin
        logic [2:0]   ro;
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic         seen_done;

        step_cycles(3);
        resetn = 1'b1;
        step_cycles(1);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_div_zero", div_zero, 0);

        push_exp(32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
        wait_done("mult", 1);

        // Issued in the cycle done is high: must be accepted.
        push_exp(32'hFFFFFFFE, 32'h00000001, 1'b0);
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("multu", 1);

        push_exp(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done("div", 1);

        push_exp(32'd1, 32'd3, 1'b0);
        issue(OP_DIVU, 32'd7, 32'd2);
        wait_done("divu", 1);

        push_exp(32'h00001234, 32'hFFFFFFFF, 1'b1);
        issue(OP_DIV, 32'h00001234, 32'd0);
        wait_done("div0", 1);

        push_exp(32'd0, 32'h80000000, 1'b0);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        chk("dz_cleared_on_start", div_zero, 0);
        wait_done("div_minneg", 1);

        for (int i = 0; i < 4; i++) begin
            ro = 3'($urandom_range(0, 3));
            rx = $urandom;
            ry = (i % 2 == 1) ? 32'($urandom_range(1, 9)) : $urandom;
            sb.push_back(model(ro, rx, ry));
            issue(ro, rx, ry);
            wait_done($sformatf("rand%0d_op%0d", i, ro), 1);
        end

        issue(OP_MTHI, 32'h11, 32'd0);
        chk("mthi_hi", hi, 32'h11);
        chk("mthi_busy", busy, 0);
        issue(OP_MTLO, 32'h22, 32'd0);
        chk("mtlo_lo", lo, 32'h22);
        chk("mtlo_done", done, 0);

        cancel = 1'b1;
        issue(OP_MTHI, 32'h99, 32'd0);
        cancel = 1'b0;
        chk("cancel_blocks_mthi", hi, 32'h11);

        issue(3'b110, 32'h55, 32'd1);
        chk("reserved_busy", busy, 0);

        issue(OP_MULT, 32'd5, 32'd7);
        step_cycles(9);
        cancel = 1'b1;
        step_cycles(1);
        cancel = 1'b0;
        chk("cancel_busy", busy, 0);
        chk("cancel_hi", hi, 32'h11);
        chk("cancel_lo", lo, 32'h22);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) seen_done = 1'b1;
            step_cycles(1);
        end
        chk("cancel_no_done", seen_done, 0);

        push_exp(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        step_cycles(4);
        start = 1'b1;
        op    = OP_MTHI;
        a     = 32'hBAD;
        step_cycles(1);
        start = 1'b0;
        chk("busy_start_ignored", hi, 32'h11);
        wait_done("div_busy_start", 6);

        issue(OP_MTHI, 32'hDEADBEEF, 32'd0);
        chk("mthi2_hi", hi, 32'hDEADBEEF);
        chk("mthi2_busy", busy, 0);
        chk("mthi2_done", done, 0);
        step_cycles(1);
        chk("mthi2_done_next", done, 0);

        issue(OP_DIVU, 32'd100, 32'd3);
        step_cycles(19);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_div_zero", div_zero, 0);
        step_cycles(2);
        resetn = 1'b1;
        step_cycles(3);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);
        push_exp(32'd1, 32'd3, 1'b0);
        issue(OP_DIVU, 32'd7, 32'd2);
        wait_done("divu_after_rst", 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
